// File: rtl/mpu_pkg.sv
// Shared MPU definitions: matrix geometry, element addressing and sequencer states.
package mpu_pkg;

    localparam int unsigned ELEM_BITS    = 8;
    localparam int unsigned MATRIX_DIM   = 5;
    localparam int unsigned MATRIX_ELEMS = MATRIX_DIM * MATRIX_DIM;
    localparam int unsigned MATRIX_BITS  = ELEM_BITS * MATRIX_ELEMS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Bit offset of element (col,row) inside a flattened matrix.
    function automatic int unsigned elem_offset(input int unsigned col, input int unsigned row);
        return ELEM_BITS * (row + MATRIX_DIM * col);
    endfunction

endpackage

// File: rtl/mpu_negate_lane.sv
// Combinational negation of LANES signed elements with a per-element min-value flag.
// MPU_OPPOSITE_SATURATE_EN: when defined, -128 saturates to +127 instead of wrapping.
module mpu_negate_lane
    import mpu_pkg::*;
#(
    parameter int unsigned LANES = 5
) (
    input  logic [LANES*ELEM_BITS-1:0] slice,
    output logic [LANES*ELEM_BITS-1:0] negated,
    output logic [LANES-1:0]           min_flag
);

    localparam logic [ELEM_BITS-1:0] MIN_VAL = {1'b1, {(ELEM_BITS-1){1'b0}}};
    localparam logic [ELEM_BITS-1:0] MAX_VAL = ~MIN_VAL;

    always_comb begin
        negated  = '0;
        min_flag = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            min_flag[i] = (slice[i*ELEM_BITS +: ELEM_BITS] == MIN_VAL);
`ifdef MPU_OPPOSITE_SATURATE_EN
            if (slice[i*ELEM_BITS +: ELEM_BITS] == MIN_VAL) begin
                negated[i*ELEM_BITS +: ELEM_BITS] = MAX_VAL;
            end else begin
                negated[i*ELEM_BITS +: ELEM_BITS] =
                    ELEM_BITS'(~slice[i*ELEM_BITS +: ELEM_BITS] + ELEM_BITS'(1));
            end
`else
            // Two's-complement wrap: -(-128) stays -128.
            negated[i*ELEM_BITS +: ELEM_BITS] =
                ELEM_BITS'(~slice[i*ELEM_BITS +: ELEM_BITS] + ELEM_BITS'(1));
`endif
        end
    end

endmodule

// File: rtl/mpu_opposite_sequencer.sv
// Multi-cycle element-wise negation of a 5x5 int8 matrix, LANES elements per cycle.
// MPU_OPPOSITE_SATURATE_EN (in mpu_negate_lane) selects saturating handling of -128.
module mpu_opposite_sequencer
    import mpu_pkg::*;
#(
    parameter int unsigned LANES = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MATRIX_BITS-1:0] matrix_a,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MATRIX_BITS-1:0] result,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned STEPS      = MATRIX_ELEMS / LANES;
    localparam int unsigned SLICE_BITS = LANES * ELEM_BITS;
    localparam int unsigned STEP_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    if (LANES != 1 && LANES != 5 && LANES != 25) begin : g_lanes_check
        $error("mpu_opposite_sequencer: LANES must be 1, 5 or 25");
    end

    seq_state_t              state, state_d;
    logic [STEP_W-1:0]       step, step_d;
    logic                    out_valid_d;
    logic                    accept;
    logic [MATRIX_BITS-1:0]  operand;
    logic [31:0]             slice_lo;
    logic [SLICE_BITS-1:0]   negated;
    logic [LANES-1:0]        min_flag;

    assign slice_lo = 32'(step) * SLICE_BITS;

    mpu_negate_lane #(.LANES(LANES)) u_lane (
        .slice    (operand[slice_lo +: SLICE_BITS]),
        .negated  (negated),
        .min_flag (min_flag)
    );

    // State register and registered handshake/status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            step      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            step      <= step_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= out_valid_d;
            busy      <= (state_d != IDLE);
        end
    end

    // Next state; out_valid rises one cycle after entering DONE and drops on handshake.
    always_comb begin
        state_d     = state;
        step_d      = step;
        out_valid_d = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    step_d  = '0;
                end
            end
            RUN: begin
                if (step == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    step_d = STEP_W'(step + 1'b1);
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            step_d      = '0;
            out_valid_d = 1'b0;
            accept      = 1'b0;
        end
    end

    // Operand capture and slice-wise result accumulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            operand  <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            operand  <= matrix_a;
            result   <= '0;
            overflow <= 1'b0;
        end else if (state == RUN && !flush) begin
            result[slice_lo +: SLICE_BITS] <= negated;
            overflow <= overflow | (|min_flag);
        end
    end

endmodule
